// File: rtl/adc_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_conv_sequencer
// Brief    : Issues ADC conversions, averages 2^n samples, streams the result.
// Revision : 1.0  initial release
// ============================================================================
module adc_conv_sequencer #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned AVG_LOG2_MAX = 4,
   parameter int unsigned TIMEOUT_CYC  = 300
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              start,
   input  logic                              continuous,
   input  logic [$clog2(AVG_LOG2_MAX+1)-1:0] avg_log2,
   input  logic                              adc_busy,
   input  logic                              adc_valid,
   input  logic [DATA_W-1:0]                 adc_count,
   output logic                              adc_restart,
   output logic [DATA_W-1:0]                 out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              seq_busy,
   output logic                              timeout_err
);

   localparam int unsigned N_W   = $clog2(AVG_LOG2_MAX+1);
   localparam int unsigned ACC_W = DATA_W + AVG_LOG2_MAX;
   localparam int unsigned CNT_W = AVG_LOG2_MAX + 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC+1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARM        = 3'd1,
      KICK       = 3'd2,
      WAIT_VALID = 3'd3,
      ACCUM      = 3'd4,
      OUTPUT     = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [N_W-1:0]    n_q, n_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              timeout_q, timeout_d;

   logic [N_W-1:0]    n_sat;
   logic [CNT_W-1:0]  last_idx;
   logic              wd_expired;

   assign n_sat      = (avg_log2 > N_W'(AVG_LOG2_MAX)) ? N_W'(AVG_LOG2_MAX) : avg_log2;
   assign last_idx   = (CNT_W'(1) << n_q) - CNT_W'(1);
   assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      wd_d       = wd_q;
      out_data_d = out_data_q;
      timeout_d  = timeout_q;
      case (state_q)
         IDLE: begin
            if (start || continuous) begin
               state_d   = ARM;
               n_d       = n_sat;
               acc_d     = '0;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         ARM: begin
            wd_d = '0;
            if (!adc_busy) state_d = KICK;
         end
         KICK, WAIT_VALID: begin
            wd_d = wd_q + WD_W'(1);
            // A result arriving on the expiry cycle still counts as a completed conversion.
            if (state_q == WAIT_VALID && adc_valid) begin
               acc_d   = acc_q + ACC_W'(adc_count);
               state_d = ACCUM;
            end else if (wd_expired) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else if (state_q == KICK && adc_busy) begin
               state_d = WAIT_VALID;
            end
         end
         ACCUM: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == last_idx) begin
               state_d    = OUTPUT;
               out_data_d = DATA_W'(acc_q >> n_q);
            end else begin
               state_d = ARM;
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               if (continuous) begin
                  state_d = ARM;
                  n_d     = n_sat;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         n_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         wd_q       <= '0;
         out_data_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         wd_q       <= wd_d;
         out_data_q <= out_data_d;
         timeout_q  <= timeout_d;
      end
   end

   assign adc_restart = (state_q == KICK);
   assign out_valid   = (state_q == OUTPUT);
   assign seq_busy    = (state_q != IDLE);
   assign out_data    = out_data_q;
   assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_conv_sequencer
// Brief    : Directed + randomized bench with an ADC model and averaging reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_conv_sequencer;

   localparam int TIMEOUT_CYC = 300;

   logic       clk = 1'b0;
   logic       rstn, start, continuous, out_ready;
   logic [2:0] avg_log2;
   logic       adc_busy, adc_valid, adc_restart;
   logic [7:0] adc_count, out_data;
   logic       out_valid, seq_busy, timeout_err;

   int         vectors = 0;
   int         miscompares = 0;
   int         restarts = 0;
   bit         hang = 1'b0;
   logic [7:0] samples[$];
   int         delivered[$];

   always #5 clk = ~clk;

   adc_conv_sequencer #(.DATA_W(8), .AVG_LOG2_MAX(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rstn(rstn), .start(start), .continuous(continuous), .avg_log2(avg_log2),
      .adc_busy(adc_busy), .adc_valid(adc_valid), .adc_count(adc_count),
      .adc_restart(adc_restart), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .seq_busy(seq_busy), .timeout_err(timeout_err)
   );

   // ADC control model: busy on restart, a few cycles of conversion, one-cycle valid, busy tail.
   initial begin
      int phase = 0;
      int conv = 0;
      adc_busy = 1'b0; adc_valid = 1'b0; adc_count = 8'h00;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            adc_busy = 1'b0; adc_valid = 1'b0; phase = 0;
         end else begin
            case (phase)
               0: if (adc_restart) begin
                     restarts++;
                     adc_busy = 1'b1;
                     conv = $urandom_range(3, 7);
                     phase = 1;
                  end
               1: begin
                     if (conv > 1) conv--;
                     else if (!hang) begin
                        adc_valid = 1'b1;
                        if (samples.size() != 0) adc_count = samples.pop_front();
                        else adc_count = 8'($urandom);
                        delivered.push_back(int'(adc_count));
                        phase = 2;
                     end
                  end
               2: begin
                     adc_valid = 1'b0;
                     adc_count = 8'($urandom);
                     phase = 3;
                  end
               default: begin
                     adc_busy = 1'b0;
                     phase = 0;
                  end
            endcase
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_out_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (out_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // Reference: result = floor(sum of delivered samples / 2^min(avg,4)).
   function automatic int ref_avg(input int nsat);
      int sum = 0;
      foreach (delivered[i]) sum += delivered[i];
      return sum >> nsat;
   endfunction

   task automatic burst(input int a, input int hold);
      int nsat, base, exp;
      bit ok;
      nsat = (a > 4) ? 4 : a;
      avg_log2 = 3'(a);
      delivered.delete();
      base = restarts;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      avg_log2 = 3'($urandom_range(0, 7));
      check("timeout_clr_on_start", timeout_err, 0);
      wait_out_valid(ok);
      check("out_valid_rise", ok, 1);
      exp = ref_avg(nsat);
      check("samples_per_burst", delivered.size(), 1 << nsat);
      check("restarts_per_burst", restarts - base, 1 << nsat);
      check("out_data", out_data, 32'(exp));
      repeat (hold) @(negedge clk);
      check("out_valid_held", out_valid, 1);
      check("out_data_held", out_data, 32'(exp));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("idle_after_accept", seq_busy, 0);
   endtask

   initial begin
      int cyc, base, exp, r0;
      bit ok;
      rstn = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b0; avg_log2 = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_adc_restart", adc_restart, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_seq_busy", seq_busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Single sample, passthrough
      samples = '{8'h5A};
      burst(0, 5);

      // Four samples 10..13 -> 46 >> 2
      samples = '{8'd10, 8'd11, 8'd12, 8'd13};
      burst(2, 1);

      // Sixteen full-scale samples, no overflow
      for (int i = 0; i < 16; i++) samples.push_back(8'hFF);
      burst(4, 2);

      // Watchdog: ADC never delivers a result
      hang = 1'b1;
      avg_log2 = 3'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!adc_restart && cyc < 100) begin @(negedge clk); cyc++; end
      cyc = 0;
      while (!timeout_err && cyc < 1000) begin @(negedge clk); cyc++; end
      check("timeout_cycles", cyc, TIMEOUT_CYC);
      check("timeout_restart_low", adc_restart, 0);
      check("timeout_idle", seq_busy, 0);
      hang = 1'b0;
      repeat (15) @(negedge clk);
      check("timeout_sticky", timeout_err, 1);
      check("stray_valid_ignored", out_valid, 0);

      // Continuous mode with 50 cycles of backpressure
      delivered.delete();
      base = restarts;
      avg_log2 = 3'd1;
      continuous = 1'b1;
      wait_out_valid(ok);
      check("cont_valid_rise", ok, 1);
      exp = ref_avg(1);
      check("cont_out_data", out_data, 32'(exp));
      r0 = restarts;
      repeat (50) @(negedge clk);
      check("cont_stall_valid", out_valid, 1);
      check("cont_stall_data", out_data, 32'(exp));
      check("cont_stall_no_restart", restarts, r0);
      check("cont_restarts", r0 - base, 2);
      delivered.delete();
      base = restarts;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("cont_valid_drop", out_valid, 0);
      check("cont_rearm", seq_busy, 1);
      wait_out_valid(ok);
      check("cont2_valid_rise", ok, 1);
      check("cont2_out_data", out_data, 32'(ref_avg(1)));
      check("cont2_restarts", restarts - base, 2);
      continuous = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("cont_stop_idle", seq_busy, 0);

      // Reset during the wait for the second sample
      base = restarts;
      avg_log2 = 3'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (restarts < base + 2 && cyc < 500) begin @(negedge clk); cyc++; end
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_adc_restart", adc_restart, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_seq_busy", seq_busy, 0);
      check("midrst_timeout_err", timeout_err, 0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      samples = '{8'd1, 8'd2, 8'd3, 8'd4};
      burst(2, 0);

      // Randomized bursts, including saturating avg_log2 codes
      for (int k = 0; k < 6; k++) burst($urandom_range(0, 7), $urandom_range(0, 4));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
